multicycle_control: RTL and testbench

Main control FSM for the multi-cycle RV32I-subset core. It decodes the 7-bit opcode held in the instruction register and sequences the shared datapath through fetch, decode, execute, memory and writeback. It drives the PC, IR, register-file, memory and mux controls, and issues the 2-bit `alu_op` consumed by the ALU-control decoder. It also handles a ready handshake with a shared, variable-latency memory port.

---
 rtl/multicycle_control_pkg.sv | 53 +++++
 rtl/multicycle_control_if.sv | 36 +++
 rtl/multicycle_control.sv | 132 +++++++++++++
 tb/tb_multicycle_control.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared RV32I-subset definitions (the riscv_defs set) for the multi-cycle core.
// Holds opcode constants, control-FSM state encodings, alu_op codes and the
// datapath mux select codes. The ALU-control decoder imports the same alu_op codes.
package multicycle_control_pkg;

    // Opcodes (IR[6:0])
    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcIAlu   = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    // Control FSM states; encodings are visible on the debug state output
    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StExecI   = 4'd7,
        StAluWb   = 4'd8,
        StBranch  = 4'd9,
        StJal     = 4'd10
    } state_e;

    // alu_op codes
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpBr    = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    // mem_to_reg select
    localparam logic [1:0] WbAluOut = 2'b00;
    localparam logic [1:0] WbMdr    = 2'b01;
    localparam logic [1:0] WbPc     = 2'b10;

    // alu_src_a select
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    // alu_src_b select
    localparam logic [1:0] SrcBRs2   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;

    // pc_source select
    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle control FSM and the shared datapath.
// master: the control FSM (drives control, observes opcode and mem_ready).
// slave:  the datapath/memory side.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic       instr_done;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal, instr_done, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal, instr_done, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I-subset core.
// Sequences fetch/decode/execute/memory/writeback over the shared datapath and
// handshakes with a variable-latency memory port via mem_ready.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; all outputs forced to 0 while high
//   bus   - master modport: opcode/mem_ready in, all datapath controls and
//           debug state out
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StFetch;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d            = state_q;
        bus.pc_write       = 1'b0;
        bus.pc_write_cond  = 1'b0;
        bus.i_or_d         = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.ir_write       = 1'b0;
        bus.reg_write      = 1'b0;
        bus.mem_to_reg     = WbAluOut;
        bus.alu_src_a      = SrcAPc;
        bus.alu_src_b      = SrcBRs2;
        bus.alu_op         = AluOpAdd;
        bus.pc_source      = PcSrcAlu;
        bus.illegal        = 1'b0;
        bus.instr_done     = 1'b0;
        bus.state          = reset ? StFetch : state_q;

        // Reset masks every control so an abandoned instruction has no side effects
        if (!reset) begin
            unique case (state_q)
                StFetch: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = SrcBFour;
                    // IR latch and PC+4 commit only when the fetch data arrives
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                    if (bus.mem_ready) state_d = StDecode;
                end
                StDecode: begin
                    // Precompute branch/jump target into ALUOut
                    bus.alu_src_a = SrcAOldPc;
                    bus.alu_src_b = SrcBImm;
                    unique case (bus.opcode)
                        OpcLoad, OpcStore: state_d = StMemAddr;
                        OpcR:              state_d = StExecR;
                        OpcIAlu:           state_d = StExecI;
                        OpcBranch:         state_d = StBranch;
                        OpcJal:            state_d = StJal;
                        default: begin
                            bus.illegal = 1'b1;
                            state_d     = StFetch;
                        end
                    endcase
                end
                StMemAddr: begin
                    bus.alu_src_a = SrcARs1;
                    bus.alu_src_b = SrcBImm;
                    state_d = (bus.opcode == OpcLoad) ? StMemRd : StMemWr;
                end
                StMemRd: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                    if (bus.mem_ready) state_d = StMemWb;
                end
                StMemWb: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = WbMdr;
                    bus.instr_done = 1'b1;
                    state_d        = StFetch;
                end
                StMemWr: begin
                    bus.mem_write  = 1'b1;
                    bus.i_or_d     = 1'b1;
                    bus.instr_done = bus.mem_ready;
                    if (bus.mem_ready) state_d = StFetch;
                end
                StExecR: begin
                    bus.alu_src_a = SrcARs1;
                    bus.alu_src_b = SrcBRs2;
                    bus.alu_op    = AluOpFunct;
                    state_d       = StAluWb;
                end
                StExecI: begin
                    bus.alu_src_a = SrcARs1;
                    bus.alu_src_b = SrcBImm;
                    bus.alu_op    = AluOpFunct;
                    state_d       = StAluWb;
                end
                StAluWb: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = WbAluOut;
                    bus.instr_done = 1'b1;
                    state_d        = StFetch;
                end
                StBranch: begin
                    bus.alu_src_a     = SrcARs1;
                    bus.alu_src_b     = SrcBRs2;
                    bus.alu_op        = AluOpBr;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = PcSrcAluOut;
                    bus.instr_done    = 1'b1;
                    state_d           = StFetch;
                end
                StJal: begin
                    // PC already holds PC+4 from FETCH; that is the link value
                    bus.pc_write   = 1'b1;
                    bus.pc_source  = PcSrcAluOut;
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = WbPc;
                    bus.instr_done = 1'b1;
                    state_d        = StFetch;
                end
                default: state_d = StFetch;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: every cycle the full control word is
// compared against a hand-written expected word.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;
    int   n_compared = 0;
    int   n_mismatched = 0;

    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Word layout: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //   reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal,
    //   instr_done, state}
    function automatic logic [22:0] cw(bit pcw, bit pwc, bit iord, bit mr, bit mw, bit irw,
                                       bit rw, logic [1:0] m2r, logic [1:0] sa,
                                       logic [1:0] sb, logic [1:0] op, logic [1:0] ps,
                                       bit ill, bit done, logic [3:0] st);
        return {pcw, pwc, iord, mr, mw, irw, rw, m2r, sa, sb, op, ps, ill, done, st};
    endfunction

    function automatic logic [22:0] observed();
        return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_write, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.pc_source, bus.illegal, bus.instr_done, bus.state};
    endfunction

    logic [22:0] e_zero, e_fetch_w, e_fetch_r, e_decode, e_decode_ill, e_memaddr, e_memrd;
    logic [22:0] e_memwb, e_memwr_r, e_execr, e_execi, e_aluwb, e_branch, e_jal;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare this cycle's outputs, then advance one clock
    task automatic cyc(input string tag, input logic [22:0] exp);
        #1;
        check(tag, {9'd0, observed()}, {9'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        e_zero       = '0;
        e_fetch_w    = cw(0,0,0,1,0,0,0, 2'd0,2'd0,2'd1,2'd0,2'd0, 0,0, 4'd0);
        e_fetch_r    = cw(1,0,0,1,0,1,0, 2'd0,2'd0,2'd1,2'd0,2'd0, 0,0, 4'd0);
        e_decode     = cw(0,0,0,0,0,0,0, 2'd0,2'd1,2'd2,2'd0,2'd0, 0,0, 4'd1);
        e_decode_ill = cw(0,0,0,0,0,0,0, 2'd0,2'd1,2'd2,2'd0,2'd0, 1,0, 4'd1);
        e_memaddr    = cw(0,0,0,0,0,0,0, 2'd0,2'd2,2'd2,2'd0,2'd0, 0,0, 4'd2);
        e_memrd      = cw(0,0,1,1,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, 0,0, 4'd3);
        e_memwb      = cw(0,0,0,0,0,0,1, 2'd1,2'd0,2'd0,2'd0,2'd0, 0,1, 4'd4);
        e_memwr_r    = cw(0,0,1,0,1,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, 0,1, 4'd5);
        e_execr      = cw(0,0,0,0,0,0,0, 2'd0,2'd2,2'd0,2'd2,2'd0, 0,0, 4'd6);
        e_execi      = cw(0,0,0,0,0,0,0, 2'd0,2'd2,2'd2,2'd2,2'd0, 0,0, 4'd7);
        e_aluwb      = cw(0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0,2'd0, 0,1, 4'd8);
        e_branch     = cw(0,1,0,0,0,0,0, 2'd0,2'd2,2'd0,2'd1,2'd1, 0,1, 4'd9);
        e_jal        = cw(1,0,0,0,0,0,1, 2'd2,2'd0,2'd0,2'd0,2'd1, 0,1, 4'd10);

        reset         = 1'b1;
        bus.mem_ready = 1'b0;
        bus.opcode    = 7'b0000000;
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc("reset_initial", e_zero);

        // LOAD stalled in MEM_RD, then reset held 3 cycles there
        reset = 1'b0;
        bus.opcode = 7'b0000011;
        bus.mem_ready = 1'b1;
        cyc("ld_abort_fetch", e_fetch_r);
        cyc("ld_abort_decode", e_decode);
        cyc("ld_abort_memaddr", e_memaddr);
        bus.mem_ready = 1'b0;
        cyc("ld_abort_memrd", e_memrd);
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        cyc("reset_memrd_1", e_zero);
        cyc("reset_memrd_2", e_zero);
        cyc("reset_memrd_3", e_zero);
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        cyc("post_reset_fetch", e_fetch_w);
        cyc("fetch_wait", e_fetch_w);

        // R-type, zero wait
        bus.opcode = 7'b0110011;
        bus.mem_ready = 1'b1;
        cyc("r_fetch", e_fetch_r);
        cyc("r_decode", e_decode);
        cyc("r_exec", e_execr);
        cyc("r_wb", e_aluwb);

        // I-ALU, zero wait
        bus.opcode = 7'b0010011;
        cyc("i_fetch", e_fetch_r);
        cyc("i_decode", e_decode);
        cyc("i_exec", e_execi);
        cyc("i_wb", e_aluwb);

        // LOAD with 2 wait cycles in MEM_RD: 7 cycles total
        bus.opcode = 7'b0000011;
        cyc("ld_fetch", e_fetch_r);
        cyc("ld_decode", e_decode);
        cyc("ld_memaddr", e_memaddr);
        bus.mem_ready = 1'b0;
        cyc("ld_memrd_w1", e_memrd);
        cyc("ld_memrd_w2", e_memrd);
        bus.mem_ready = 1'b1;
        cyc("ld_memrd_rdy", e_memrd);
        cyc("ld_memwb", e_memwb);

        // STORE, zero wait
        bus.opcode = 7'b0100011;
        cyc("st_fetch", e_fetch_r);
        cyc("st_decode", e_decode);
        cyc("st_memaddr", e_memaddr);
        cyc("st_memwr", e_memwr_r);

        // BRANCH then JAL back-to-back
        bus.opcode = 7'b1100011;
        cyc("br_fetch", e_fetch_r);
        cyc("br_decode", e_decode);
        cyc("br_exec", e_branch);
        bus.opcode = 7'b1101111;
        cyc("jal_fetch", e_fetch_r);
        cyc("jal_decode", e_decode);
        cyc("jal_exec", e_jal);

        // Illegal opcode
        bus.opcode = 7'b0000000;
        cyc("ill_fetch", e_fetch_r);
        cyc("ill_decode", e_decode_ill);
        bus.mem_ready = 1'b0;
        cyc("ill_refetch", e_fetch_w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
